// File: rtl/draw_channel_bars.sv
// draw_channel_bars: overlays up to 13 vertical level bars on a VGA stream.
// Samples are written into shadow registers at any time. They are copied to the
// active set on each vblnk rising edge, so a frame never shows a half-updated set.
// The VGA bus is delayed by a two-stage pipeline: hit/colour, then output.

`ifndef VGA_BUS_SIZE
`define VGA_BUS_SIZE 38
`endif

`ifndef VGA_SPLIT_INPUT
`define VGA_SPLIT_INPUT(BUS) \
    logic [10:0] hcount_in; \
    logic        hsync_in; \
    logic        hblnk_in; \
    logic [10:0] vcount_in; \
    logic        vsync_in; \
    logic        vblnk_in; \
    logic [11:0] rgb_in; \
    assign {hcount_in, hsync_in, hblnk_in, vcount_in, vsync_in, vblnk_in, rgb_in} = BUS;
`endif

`ifndef VGA_MERGE_OUTPUT
`define VGA_MERGE_OUTPUT(BUS) \
    assign BUS = {hcount_out, hsync_out, hblnk_out, vcount_out, vsync_out, vblnk_out, rgb_out};
`endif

module draw_channel_bars #(
    parameter int          BAR_X0     = 256,
    parameter int          BAR_W      = 40,
    parameter int          BAR_GAP    = 16,
    parameter int          BAR_Y_BASE = 480,
    parameter logic [11:0] COL_OK     = 12'h0F0,
    parameter logic [11:0] COL_WARN   = 12'hFF0,
    parameter logic [11:0] COL_HIGH   = 12'hF00
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic [`VGA_BUS_SIZE-1:0] vga_in,
    output logic [`VGA_BUS_SIZE-1:0] vga_out,
    input  logic                     ch_wr_en,
    input  logic [3:0]               ch_wr_idx,
    input  logic [11:0]              ch_wr_data,
    input  logic [12:0]              ch_en,
    output logic                     frame_loaded
);

    localparam int NCH = 13;

    `VGA_SPLIT_INPUT(vga_in)

    function automatic logic [11:0] bar_colour(input logic [11:0] level);
        if (level >= 12'hE00)      return COL_HIGH;
        else if (level >= 12'hA00) return COL_WARN;
        else                       return COL_OK;
    endfunction

    logic [11:0] shadow_q [NCH];
    logic [11:0] active_q [NCH];
    logic [12:0] act_en_q;
    logic        vblnk_prev_q;
    logic        frame_loaded_q;
    logic        load_edge;

    assign load_edge = vblnk_in & ~vblnk_prev_q;

    // Sample capture into shadow, frame-synchronous copy into the active set
    always_ff @(posedge pclk) begin
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_q[i] <= '0;
                active_q[i] <= '0;
            end
            act_en_q       <= '0;
            vblnk_prev_q   <= 1'b0;
            frame_loaded_q <= 1'b0;
        end else begin
            // Non-blocking copy takes the pre-write shadow value on a coincident write
            if (load_edge) begin
                for (int i = 0; i < NCH; i++) active_q[i] <= shadow_q[i];
                act_en_q <= ch_en;
            end
            if (ch_wr_en && (ch_wr_idx <= 4'd12)) shadow_q[ch_wr_idx] <= ch_wr_data;
            vblnk_prev_q   <= vblnk_in;
            frame_loaded_q <= load_edge;
        end
    end

    assign frame_loaded = frame_loaded_q;

    // Per-bar hit tests; x spans are elaboration-time constants
    logic [NCH-1:0] bar_hit;
    for (genvar k = 0; k < NCH; k++) begin : g_bar
        localparam int XL = BAR_X0 + k * (BAR_W + BAR_GAP);
        localparam int XR = XL + BAR_W - 1;
        logic [7:0]  h;
        logic [11:0] ytop;
        assign h    = active_q[k][11:4];
        assign ytop = 12'(BAR_Y_BASE) - {4'd0, h};
        assign bar_hit[k] = act_en_q[k] && (h != 8'd0)
                         && ({1'b0, hcount_in} >= 12'(XL))
                         && ({1'b0, hcount_in} <= 12'(XR))
                         && ({1'b0, vcount_in} >= ytop)
                         && ({1'b0, vcount_in} <= 12'(BAR_Y_BASE - 1));
    end

    logic        hit_d;
    logic [11:0] col_d;

    // Pick the colour of the lowest-index bar hit (later iterations win)
    always_comb begin
        hit_d = |bar_hit;
        col_d = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (bar_hit[k]) col_d = bar_colour(active_q[k]);
        end
    end

    logic        hit_p1_q;
    logic [11:0] col_p1_q;
    logic [10:0] hcount_p1_q, vcount_p1_q;
    logic        hsync_p1_q, hblnk_p1_q, vsync_p1_q, vblnk_p1_q;
    logic [11:0] rgb_p1_q;

    // Stage 1: register hit, colour and the delayed bus
    always_ff @(posedge pclk) begin
        if (rst) begin
            hit_p1_q    <= 1'b0;
            col_p1_q    <= '0;
            hcount_p1_q <= '0;
            hsync_p1_q  <= 1'b0;
            hblnk_p1_q  <= 1'b0;
            vcount_p1_q <= '0;
            vsync_p1_q  <= 1'b0;
            vblnk_p1_q  <= 1'b0;
            rgb_p1_q    <= '0;
        end else begin
            hit_p1_q    <= hit_d;
            col_p1_q    <= col_d;
            hcount_p1_q <= hcount_in;
            hsync_p1_q  <= hsync_in;
            hblnk_p1_q  <= hblnk_in;
            vcount_p1_q <= vcount_in;
            vsync_p1_q  <= vsync_in;
            vblnk_p1_q  <= vblnk_in;
            rgb_p1_q    <= rgb_in;
        end
    end

    logic [11:0] rgb_d;
    assign rgb_d = (hblnk_p1_q || vblnk_p1_q || !hit_p1_q) ? rgb_p1_q : col_p1_q;

    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, hblnk_out, vsync_out, vblnk_out;
    logic [11:0] rgb_out;

    // Stage 2: register the outputs
    always_ff @(posedge pclk) begin
        if (rst) begin
            hcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vcount_out <= '0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_p1_q;
            hsync_out  <= hsync_p1_q;
            hblnk_out  <= hblnk_p1_q;
            vcount_out <= vcount_p1_q;
            vsync_out  <= vsync_p1_q;
            vblnk_out  <= vblnk_p1_q;
            rgb_out    <= rgb_d;
        end
    end

    `VGA_MERGE_OUTPUT(vga_out)

endmodule
